// File: rtl/servo_array_if.sv
// Command port for servo_array: one position write per valid&ready handshake.
// The bench or sequencer drives master; the controller consumes slave.
interface servo_array_if #(
  parameter int CH_W    = 2,
  parameter int POS_LEN = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic [POS_LEN-1:0] cmd_pos;

  modport master (output cmd_valid, output cmd_ch, output cmd_pos, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_array.sv
// Multi-channel servo PWM: shared prescaler/frame counter, per-channel slew, settle and done.
// Command accepted on the edge it is seen (done drops next cycle); cmd_ready is low only in the frame-boundary cycle.
module servo_array #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int POS_LEN  = 8,
  parameter int PWM_LEN  = 12,
  parameter int PWM_MAX  = 2000,
  parameter int PW_MIN   = 100,
  parameter int FD_LEN   = 12,
  parameter int FD_F     = 250,
  parameter int STEP     = 4,
  parameter int WAITTIME = 100,
  parameter int RST_POS  = 128
) (
  input  logic             clk,
  input  logic             rst,
  servo_array_if.slave     cmd,
  output logic [NCH-1:0]   pwm,
  output logic [NCH-1:0]   done,
  output logic             frame,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} st_t;

  localparam int WT_W = (WAITTIME > 1) ? $clog2(WAITTIME) : 1;

  logic [FD_LEN-1:0]  r_pre;
  logic [PWM_LEN-1:0] r_fc;
  logic               r_frame;
  logic               r_err;
  logic               w_tick;
  logic               w_fb;
  logic               w_acc;
  logic               w_bad;

  assign w_tick        = (r_pre == FD_LEN'(FD_F - 1));
  assign w_fb          = w_tick && (r_fc == PWM_LEN'(PWM_MAX - 1));
  // Holding off commands in the boundary cycle keeps target loads and slew updates disjoint.
  assign cmd.cmd_ready = ~rst & ~w_fb;
  assign w_acc         = cmd.cmd_valid & cmd.cmd_ready;
  assign w_bad         = (32'(cmd.cmd_ch) >= NCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_fc    <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + FD_LEN'(1);
      if (w_tick) begin
        r_fc <= w_fb ? '0 : r_fc + PWM_LEN'(1);
      end
      r_frame <= w_fb;
      r_err   <= w_acc & w_bad;
    end
  end

  assign frame = r_frame;
  assign err   = r_err;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    st_t                r_st;
    st_t                w_st_nxt;
    logic [POS_LEN-1:0] r_cur;
    logic [POS_LEN-1:0] r_tgt;
    logic [POS_LEN-1:0] w_cur_nxt;
    logic [POS_LEN-1:0] w_tgt_nxt;
    logic [POS_LEN-1:0] w_slew;
    logic [POS_LEN:0]   w_diff;
    logic [WT_W-1:0]    r_wait;
    logic [WT_W-1:0]    w_wait_nxt;
    logic               w_hit;
    logic               r_pwm;
    logic               r_done;

    assign w_hit = w_acc && (cmd.cmd_ch == CH_W'(g));

    always_comb begin
      w_st_nxt   = r_st;
      w_tgt_nxt  = r_tgt;
      w_cur_nxt  = r_cur;
      w_wait_nxt = r_wait;
      w_diff     = '0;
      w_slew     = r_cur;
      // Distance in POS_LEN+1 bits; a step larger than the gap lands exactly on target.
      if (r_tgt > r_cur) begin
        w_diff = {1'b0, r_tgt} - {1'b0, r_cur};
        w_slew = (w_diff > (POS_LEN+1)'(STEP)) ? r_cur + POS_LEN'(STEP) : r_tgt;
      end else if (r_tgt < r_cur) begin
        w_diff = {1'b0, r_cur} - {1'b0, r_tgt};
        w_slew = (w_diff > (POS_LEN+1)'(STEP)) ? r_cur - POS_LEN'(STEP) : r_tgt;
      end

      if (w_hit) begin
        w_tgt_nxt  = cmd.cmd_pos;
        w_st_nxt   = MOVE;
        w_wait_nxt = '0;
      end else if (w_fb) begin
        w_cur_nxt = w_slew;
        unique case (r_st)
          MOVE: begin
            if (w_slew == r_tgt) begin
              w_st_nxt   = (WAITTIME == 0) ? IDLE : SETTLE;
              w_wait_nxt = '0;
            end
          end
          SETTLE: begin
            if (32'(r_wait) == 32'(WAITTIME - 1)) w_st_nxt = IDLE;
            else                                  w_wait_nxt = r_wait + WT_W'(1);
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st   <= IDLE;
        r_cur  <= POS_LEN'(RST_POS);
        r_tgt  <= POS_LEN'(RST_POS);
        r_wait <= '0;
        r_pwm  <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_st   <= w_st_nxt;
        r_cur  <= w_cur_nxt;
        r_tgt  <= w_tgt_nxt;
        r_wait <= w_wait_nxt;
        r_pwm  <= (r_fc < (PWM_LEN'(PW_MIN) + PWM_LEN'(r_cur)));
        r_done <= (w_st_nxt == IDLE);
      end
    end

    assign pwm[g]  = r_pwm;
    assign done[g] = r_done;
  end

endmodule

// File: tb/tb_servo_array.sv
// Directed bench for servo_array: FD_F=2, PWM_MAX=400, PW_MIN=50, STEP=16, WAITTIME=3, RST_POS=128.
// Widths are measured in ticks per 800-clk frame starting at the frame pulse.
module tb_servo_array;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  servo_array_if #(.CH_W(2), .POS_LEN(8)) cif ();
  servo_array_if #(.CH_W(2), .POS_LEN(8)) cif3 ();

  logic [3:0] pwm, done;
  logic       frame, err;
  logic [2:0] pwm3, done3;
  logic       frame3, err3;

  servo_array #(
    .NCH(4), .CH_W(2), .POS_LEN(8), .PWM_LEN(12), .PWM_MAX(400), .PW_MIN(50),
    .FD_LEN(12), .FD_F(2), .STEP(16), .WAITTIME(3), .RST_POS(128)
  ) u_dut (
    .clk(clk), .rst(rst), .cmd(cif), .pwm(pwm), .done(done), .frame(frame), .err(err)
  );

  servo_array #(
    .NCH(3), .CH_W(2), .POS_LEN(8), .PWM_LEN(12), .PWM_MAX(400), .PW_MIN(50),
    .FD_LEN(12), .FD_F(2), .STEP(16), .WAITTIME(3), .RST_POS(128)
  ) u_dut3 (
    .clk(clk), .rst(rst), .cmd(cif3), .pwm(pwm3), .done(done3), .frame(frame3), .err(err3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int wd[4];
  int fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (frame !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wait", frame, 1);
  endtask

  // Called at the negedge of a frame-pulse cycle; returns at the next one.
  task automatic meas();
    int c[4];
    int f;
    f = 0;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) if (pwm[i]) c[i]++;
      if (frame) f++;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) wd[i] = c[i] / 2;
    fcnt = f;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] pos);
    cif.cmd_valid = 1'b1;
    cif.cmd_ch    = ch;
    cif.cmd_pos   = pos;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  int exp1[8]  = '{194, 210, 226, 242, 250, 250, 250, 250};
  int dn1[8]   = '{0, 0, 0, 0, 0, 0, 0, 1};
  int exp2[9]  = '{162, 146, 130, 114, 98, 82, 66, 50, 50};
  int exp0[9]  = '{226, 242, 258, 274, 290, 305, 305, 305, 305};

  initial begin
    cif.cmd_valid  = 1'b0; cif.cmd_ch  = '0; cif.cmd_pos  = '0;
    cif3.cmd_valid = 1'b0; cif3.cmd_ch = '0; cif3.cmd_pos = '0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_done", done, 4'hF);
    chk("rst_done3", done3, 3'h7);
    chk("rst_frame", frame, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cif.cmd_ready, 1);

    // Idle frames: all channels at 128 -> 178 ticks.
    wait_frame();
    meas();
    for (int i = 0; i < 4; i++) chk($sformatf("idle_w%0d", i), wd[i], 178);
    chk("frame_count", fcnt, 1);
    chk("frame_period", frame, 1);
    chk("idle_done", done, 4'hF);

    // ch1 -> 200
    send(2'd1, 8'd200);
    chk("ch1_done_drop", done, 4'b1101);
    wait_frame();
    for (int f = 0; f < 8; f++) begin
      chk($sformatf("ch1_done_f%0d", f), done[1], dn1[f]);
      meas();
      chk($sformatf("ch1_w_f%0d", f), wd[1], exp1[f]);
      chk($sformatf("ch1_w0_f%0d", f), wd[0], 178);
      chk($sformatf("ch1_w3_f%0d", f), wd[3], 178);
    end

    // ch2 -> 0: eight -16 steps then hold at 0.
    send(2'd2, 8'd0);
    wait_frame();
    for (int f = 0; f < 9; f++) begin
      meas();
      chk($sformatf("ch2_w_f%0d", f), wd[2], exp2[f]);
    end
    chk("ch2_settling", done[2], 0);

    // ch0 -> 160, then -> 255 during SETTLE.
    send(2'd0, 8'd160);
    wait_frame();
    meas();
    chk("ch0_w144", wd[0], 194);
    meas();
    chk("ch0_w160", wd[0], 210);
    chk("ch0_settle_done", done[0], 0);
    send(2'd0, 8'd255);
    chk("ch0_retarget_done", done[0], 0);
    wait_frame();
    for (int f = 0; f < 9; f++) begin
      chk($sformatf("ch0_done_f%0d", f), done[0], (f == 8) ? 1 : 0);
      meas();
      chk($sformatf("ch0_w_f%0d", f), wd[0], exp0[f]);
    end

    // cmd_valid spanning the boundary cycle.
    chk("ready_normal", cif.cmd_ready, 1);
    repeat (799) @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_ch = 2'd3; cif.cmd_pos = 8'd128;
    chk("ready_fb", cif.cmd_ready, 0);
    chk("frame_before_fb", frame, 0);
    @(negedge clk);
    chk("ready_after_fb", cif.cmd_ready, 1);
    chk("frame_after_fb", frame, 1);
    chk("held_not_accepted", done[3], 1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("held_accepted", done[3], 0);
    chk("ch3_no_err", err, 0);

    // Out-of-range channel on the NCH=3 instance.
    cif3.cmd_valid = 1'b1; cif3.cmd_ch = 2'd2; cif3.cmd_pos = 8'd10;
    @(negedge clk);
    chk("n3_ch2_err", err3, 0);
    chk("n3_ch2_done", done3, 3'b011);
    cif3.cmd_ch = 2'd3;
    @(negedge clk);
    cif3.cmd_valid = 1'b0;
    chk("n3_bad_err", err3, 1);
    chk("n3_bad_done", done3, 3'b011);
    @(negedge clk);
    chk("n3_err_pulse", err3, 0);
    chk("n3_done_hold", done3, 3'b011);

    // Reset mid-pulse during MOVE.
    send(2'd1, 8'd0);
    wait_frame();
    repeat (100) @(negedge clk);
    chk("pre_rst_pwm1", pwm[1], 1);
    rst = 1'b1;
    #1;
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_done", done, 4'hF);
    chk("async_rst_ready", cif.cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_frame();
    meas();
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst_w%0d", i), wd[i], 178);
    chk("post_rst_done", done, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
